// File: rtl/demux_latch8.sv
// demux_latch8: clocked 1-of-N demultiplexer / addressable latch (74LS259 modes).
// Steers serial bit D onto one of NUM_OUT registered outputs. The address comes
// from the external bus S, or from an auto-incrementing pointer for
// serial-to-parallel capture.

// One output bit. Applies the latch/memory/demux/clear function table locally,
// given the shared strobes and whether this lane is the addressed one.
module demux_latch8_lane (
   input  logic CLK,
   input  logic RST_n,
   input  logic hit,     // this lane is the effective address
   input  logic wr,      // G_n low: write strobe
   input  logic clr,     // CLR_n low: demux/clear mode
   input  logic d,
   output logic q
);

   // A lane that is not addressed keeps its value, unless clr forces it low.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n)         q <= 1'b0;
      else if (wr && hit) q <= d;
      else if (clr)       q <= 1'b0;
   end

endmodule

module demux_latch8 #(
   parameter  int ADDR_W  = 3,
   localparam int NUM_OUT = 2 ** ADDR_W
) (
   input  logic               CLK,
   input  logic               RST_n,
   input  logic               G_n,
   input  logic               CLR_n,
   input  logic               MODE,
   input  logic [ADDR_W-1:0]  S,
   input  logic               D,
   output logic [NUM_OUT-1:0] Q,
   output logic [ADDR_W-1:0]  PTR,
   output logic               FRAME_DONE
);

   logic              wr;
   logic              clr;
   logic              ptr_wr;
   logic [ADDR_W-1:0] addr;

   assign wr     = ~G_n;
   assign clr    = ~CLR_n;
   // The pointer only moves on writes that actually use it as the address.
   assign ptr_wr = wr & MODE;
   assign addr   = MODE ? PTR : S;

   // One lane per output bit, each comparing itself against the shared address.
   for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
      demux_latch8_lane u_lane (
         .CLK   (CLK),
         .RST_n (RST_n),
         .hit   (addr == ADDR_W'(i)),
         .wr    (wr),
         .clr   (clr),
         .d     (D),
         .q     (Q[i])
      );
   end

   // Pointer: zeroed by clear mode, otherwise advances on pointer-addressed
   // writes. NUM_OUT is a power of two, so the natural overflow is the wrap.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n)          PTR <= '0;
      else if (clr && !wr) PTR <= '0;
      else if (ptr_wr)     PTR <= PTR + 1'b1;
   end

   // Frame pulse: the write that filled the last slot. Clear mode cannot
   // coincide, since it requires G_n high.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) FRAME_DONE <= 1'b0;
      else        FRAME_DONE <= ptr_wr & (&PTR);
   end

endmodule

// File: tb/tb_demux_latch8.sv
// Directed bench for demux_latch8: reset, latch/memory, demux/clear, serial
// capture, gaps with a mode switch, back-to-back frames and reset mid-frame.
module tb_demux_latch8;

   logic       CLK = 1'b0;
   logic       RST_n = 1'b0;
   logic       G_n = 1'b1;
   logic       CLR_n = 1'b1;
   logic       MODE = 1'b0;
   logic [2:0] S = '0;
   logic       D = 1'b0;
   logic [7:0] Q;
   logic [2:0] PTR;
   logic       FRAME_DONE;

   int n_cmp = 0;
   int n_err = 0;

   demux_latch8 #(.ADDR_W(3)) dut (
      .CLK        (CLK),
      .RST_n      (RST_n),
      .G_n        (G_n),
      .CLR_n      (CLR_n),
      .MODE       (MODE),
      .S          (S),
      .D          (D),
      .Q          (Q),
      .PTR        (PTR),
      .FRAME_DONE (FRAME_DONE)
   );

   always #5 CLK = ~CLK;

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      step();
      RST_n = 1'b1;
      // Pointer write to bit 0, then external writes to bits 2,5,7 -> A5
      MODE = 1'b1; G_n = 1'b0; D = 1'b1;
      step();
      MODE = 1'b0; S = 3'd2; step();
      S = 3'd5; step();
      S = 3'd7; step();
      G_n = 1'b1;
      n_cmp++; if (Q !== 8'hA5) begin n_err++; $display("FAIL rst_preload Q got %h want a5", Q); end
      n_cmp++; if (PTR !== 3'd1) begin n_err++; $display("FAIL rst_preload PTR got %0d want 1", PTR); end
      #2 RST_n = 1'b0;
      #1;
      n_cmp++; if (Q !== 8'h00) begin n_err++; $display("FAIL rst_async Q got %h want 00", Q); end
      n_cmp++; if (PTR !== 3'd0) begin n_err++; $display("FAIL rst_async PTR got %0d want 0", PTR); end
      n_cmp++; if (FRAME_DONE !== 1'b0) begin n_err++; $display("FAIL rst_async FRAME_DONE got %b want 0", FRAME_DONE); end
      step();
      RST_n = 1'b1;
   endtask

   task automatic test_latch();
      logic [7:0] exp_q [3] = '{8'h08, 8'h48, 8'h40};
      logic [2:0] s_v   [3] = '{3'd3, 3'd6, 3'd3};
      logic       d_v   [3] = '{1'b1, 1'b1, 1'b0};
      MODE = 1'b0; CLR_n = 1'b1; G_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         S = s_v[i]; D = d_v[i];
         step();
         n_cmp++; if (Q !== exp_q[i]) begin n_err++; $display("FAIL latch_%0d Q got %h want %h", i, Q, exp_q[i]); end
      end
      G_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         D = ~D; S = 3'(i);
         step();
         n_cmp++; if (Q !== 8'h40) begin n_err++; $display("FAIL memory_%0d Q got %h want 40", i, Q); end
      end
   endtask

   task automatic test_demux_clear();
      // Load FF: bit 0 via the pointer (leaves PTR=1), bits 1..7 via S
      CLR_n = 1'b1; G_n = 1'b0; D = 1'b1; MODE = 1'b1;
      step();
      MODE = 1'b0;
      for (int i = 1; i < 8; i++) begin
         S = 3'(i);
         step();
      end
      n_cmp++; if (Q !== 8'hFF) begin n_err++; $display("FAIL demux_load Q got %h want ff", Q); end
      CLR_n = 1'b0; G_n = 1'b0; S = 3'd5; D = 1'b1;
      step();
      n_cmp++; if (Q !== 8'h20) begin n_err++; $display("FAIL demux Q got %h want 20", Q); end
      n_cmp++; if (PTR !== 3'd1) begin n_err++; $display("FAIL demux_ptr_hold PTR got %0d want 1", PTR); end
      // Demux in pointer mode: zeroes others, writes Q[1], advances PTR
      MODE = 1'b1;
      step();
      n_cmp++; if (Q !== 8'h02) begin n_err++; $display("FAIL demux_ptr Q got %h want 02", Q); end
      n_cmp++; if (PTR !== 3'd2) begin n_err++; $display("FAIL demux_ptr PTR got %0d want 2", PTR); end
      G_n = 1'b1; MODE = 1'b0;
      step();
      n_cmp++; if (Q !== 8'h00) begin n_err++; $display("FAIL clear Q got %h want 00", Q); end
      n_cmp++; if (PTR !== 3'd0) begin n_err++; $display("FAIL clear PTR got %0d want 0", PTR); end
      CLR_n = 1'b1;
   endtask

   task automatic test_serial();
      logic [7:0] bits = 8'b0100_1101; // D sequence 1,0,1,1,0,0,1,0 from bit 0
      MODE = 1'b1; CLR_n = 1'b1; G_n = 1'b0; S = 3'd6;
      for (int i = 0; i < 8; i++) begin
         D = bits[i];
         step();
         if (i < 7) begin
            n_cmp++; if (FRAME_DONE !== 1'b0) begin n_err++; $display("FAIL serial_fd_%0d got %b want 0", i, FRAME_DONE); end
         end
      end
      G_n = 1'b1;
      n_cmp++; if (Q !== 8'h4D) begin n_err++; $display("FAIL serial Q got %h want 4d", Q); end
      n_cmp++; if (FRAME_DONE !== 1'b1) begin n_err++; $display("FAIL serial_fd got %b want 1", FRAME_DONE); end
      n_cmp++; if (PTR !== 3'd0) begin n_err++; $display("FAIL serial PTR got %0d want 0", PTR); end
      step();
      n_cmp++; if (FRAME_DONE !== 1'b0) begin n_err++; $display("FAIL serial_fd_end got %b want 0", FRAME_DONE); end
   endtask

   task automatic test_gaps();
      logic [4:0] tail = 5'b10000; // PTR 3..7 get 0,0,0,0,1
      MODE = 1'b1; G_n = 1'b0; D = 1'b1;
      for (int i = 0; i < 3; i++) step();
      n_cmp++; if (PTR !== 3'd3) begin n_err++; $display("FAIL gap_3w PTR got %0d want 3", PTR); end
      G_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         D = ~D;
         step();
         n_cmp++; if (PTR !== 3'd3) begin n_err++; $display("FAIL gap_%0d PTR got %0d want 3", i, PTR); end
         n_cmp++; if (FRAME_DONE !== 1'b0) begin n_err++; $display("FAIL gap_fd_%0d got %b want 0", i, FRAME_DONE); end
      end
      MODE = 1'b0; G_n = 1'b0; S = 3'd7; D = 1'b0;
      step();
      n_cmp++; if (PTR !== 3'd3) begin n_err++; $display("FAIL gap_mode0 PTR got %0d want 3", PTR); end
      n_cmp++; if (Q !== 8'h4F) begin n_err++; $display("FAIL gap_mode0 Q got %h want 4f", Q); end
      MODE = 1'b1; S = 3'd0;
      for (int i = 0; i < 5; i++) begin
         D = tail[i];
         step();
         n_cmp++;
         if (FRAME_DONE !== (i == 4)) begin n_err++; $display("FAIL gap_tail_fd_%0d got %b want %b", i, FRAME_DONE, (i == 4)); end
      end
      n_cmp++; if (Q !== 8'h87) begin n_err++; $display("FAIL gap_frame Q got %h want 87", Q); end
      // Back-to-back frame, no gap cycle
      D = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_cmp++;
         if (FRAME_DONE !== (i == 7)) begin n_err++; $display("FAIL b2b_fd_%0d got %b want %b", i, FRAME_DONE, (i == 7)); end
      end
      n_cmp++; if (Q !== 8'hFF) begin n_err++; $display("FAIL b2b Q got %h want ff", Q); end
      G_n = 1'b1;
   endtask

   task automatic test_reset_midframe();
      logic [7:0] bits = 8'b1011_0010; // D sequence 0,1,0,0,1,1,0,1 from bit 0
      MODE = 1'b1; G_n = 1'b0; D = 1'b1;
      for (int i = 0; i < 5; i++) step();
      n_cmp++; if (PTR !== 3'd5) begin n_err++; $display("FAIL mid_pre PTR got %0d want 5", PTR); end
      RST_n = 1'b0;
      step();
      RST_n = 1'b1;
      n_cmp++; if (PTR !== 3'd0) begin n_err++; $display("FAIL mid_rst PTR got %0d want 0", PTR); end
      n_cmp++; if (Q !== 8'h00) begin n_err++; $display("FAIL mid_rst Q got %h want 00", Q); end
      for (int i = 0; i < 8; i++) begin
         D = bits[i];
         step();
         n_cmp++;
         if (FRAME_DONE !== (i == 7)) begin n_err++; $display("FAIL mid_fd_%0d got %b want %b", i, FRAME_DONE, (i == 7)); end
      end
      G_n = 1'b1;
      n_cmp++; if (Q !== 8'hB2) begin n_err++; $display("FAIL mid_frame Q got %h want b2", Q); end
      n_cmp++; if (PTR !== 3'd0) begin n_err++; $display("FAIL mid_frame PTR got %0d want 0", PTR); end
   endtask

   initial begin
      test_reset();
      test_latch();
      test_demux_clear();
      test_serial();
      test_gaps();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/demux_latch8.md
Name: demux_latch8

Overview:
- Clocked 1-of-N demultiplexer / addressable latch, modelled on 74LS259 function modes.
- Inverse of the 4:1 data selector: steers a single serial data bit `D` onto one of `NUM_OUT` registered parallel outputs.
- Address comes from the external select bus or from an internal auto-incrementing pointer, for serial-to-parallel capture.
- Sits downstream of selector/serialiser blocks in the logic-family library.

Parameters:
- `ADDR_W`, default 3: address width.
- `NUM_OUT`, default `2**ADDR_W` (derived, not overridable): number of outputs.

Ports:
- `CLK` input 1: sole clock, rising edge.
- `RST_n` input 1: asynchronous active-low reset.
- `G_n` input 1: active-low enable (write strobe).
- `CLR_n` input 1: active-low clear/demux mode select.
- `MODE` input 1: address source. 0 = external `S`, 1 = internal pointer `PTR`.
- `S` input `ADDR_W`: external address.
- `D` input 1: data bit.
- `Q` output `NUM_OUT`: latched outputs, `Q[i]` = output i.
- `PTR` output `ADDR_W`: current internal pointer.
- `FRAME_DONE` output 1: one-cycle pulse, a full `NUM_OUT`-bit frame has been captured in `MODE`=1.

Behaviour:
- Reset: one clock `CLK`; `RST_n` asynchronous, active-low. On `RST_n`=0, immediately `Q`=0, `PTR`=0, `FRAME_DONE`=0, regardless of `CLK`. Deassertion takes effect at the next rising edge.
- All outputs registered; no tri-state. Effect of inputs at edge k visible after edge k (latency 1).
- Effective address `addr` = `MODE` ? `PTR` : `S`.
- Function table, evaluated at each rising `CLK`:
  - `CLR_n`=1, `G_n`=0 (addressable latch): `Q[addr]` <= `D`; all other bits hold.
  - `CLR_n`=1, `G_n`=1 (memory): `Q` holds.
  - `CLR_n`=0, `G_n`=0 (demux): `Q` <= 0 except `Q[addr]` <= `D`.
  - `CLR_n`=0, `G_n`=1 (clear): `Q` <= 0; `PTR` <= 0.
- Pointer:
  - Advances only on a write (`G_n`=0) with `MODE`=1: `PTR` <= `PTR`+1 modulo `NUM_OUT` (wraps `NUM_OUT`-1 -> 0). Applies in both latch and demux writes.
  - `MODE`=0: `PTR` holds (except clear mode, which zeroes it).
  - Switching `MODE` mid-frame does not disturb `PTR`; capture resumes at the held position.
- `FRAME_DONE`:
  - Asserted for exactly one cycle after an edge where a `MODE`=1 write occurred with `PTR`=`NUM_OUT`-1.
  - Deasserted after every other edge.
  - Back-to-back frames give one pulse every `NUM_OUT` write cycles, with no gap cycle required.
- Simultaneous events:
  - Clear mode overrides any pointer advance.
  - Demux-mode write in `MODE`=1 both zeroes other bits and advances `PTR`.
- `S` is ignored when `MODE`=1. `D` is ignored when `G_n`=1.
- Reset mid-frame aborts the frame: no `FRAME_DONE`, `PTR` restarts at 0.
- No X propagation: `Q` bits not addressed keep their prior defined value.
- Implementation size: ~120-200 lines.

Test Plan:
- Reset: drive `RST_n`=0 asynchronously mid-cycle after loading `Q`=8'hA5 -> `Q`=0, `PTR`=0, `FRAME_DONE`=0 before the next `CLK` edge.
- Addressable latch:
  - With `MODE`=0, `CLR_n`=1, `G_n`=0, write `S`=3/`D`=1, then `S`=6/`D`=1, then `S`=3/`D`=0 -> `Q`=8'h08, 8'h48, 8'h40 after successive edges.
  - Then `G_n`=1 with `D` toggling -> `Q` stays 8'h40.
- Demux and clear:
  - From `Q`=8'hFF, `CLR_n`=0, `G_n`=0, `S`=5, `D`=1 -> `Q`=8'h20.
  - Then `CLR_n`=0, `G_n`=1 -> `Q`=0, `PTR`=0.
- Serial capture: `MODE`=1, `G_n`=0 for 8 cycles with `D` sequence 1,0,1,1,0,0,1,0 (`PTR` 0..7) ->
  - `Q`=8'h4D after the 8th edge.
  - `FRAME_DONE`=1 for exactly that following cycle.
  - `PTR`=0.
- Gaps and mode switch:
  - `MODE`=1, write 3 bits, then `G_n`=1 for 2 cycles, then `MODE`=0 write `S`=7, then `MODE`=1 write 5 more bits.
  - Expected: `PTR` holds at 3 during the gap and the `MODE`=0 write; `FRAME_DONE` pulses once, after the 8th pointer write.
  - Continuing writes with no gap -> next pulse exactly 8 writes later.
- Reset mid-frame: `MODE`=1, 5 writes, assert `RST_n`=0 for 1 cycle, then 8 writes -> `FRAME_DONE` pulses only after the 8th post-reset write; `Q` reflects only post-reset data.
